led_breath_ctrl: RTL and testbench
==================================

Name: led_breath_ctrl

Overview:
- Multi-channel LED dimming controller driving board LEDs directly.
- Generalises the single-rate breathing LED with a parametrised tick divider, PWM resolution and channel count.
- Adds run-time mode select (off / on / breathe / blink), per-channel phase inversion, an enable and a cycle-complete pulse.

Parameters:
- CLK_DIV, 50: clk cycles per PWM tick (1 us at 50 MHz); must be >= 1.
- STEPS, 1000: PWM ticks per PWM period, and also the number of duty ramp steps; must be >= 2.
- CH, 4: number of LED channels.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  synchronous enable; low holds the block idle.
- mode  in  2  00 off, 01 on, 10 breathe, 11 blink.
- phase_inv  in  CH  per-channel inversion: complementary duty in breathe, inverted level in blink.
- led  out  CH  registered LED drive, active high.
- cycle_done  out  1  one-clk pulse at the end of each full breathe cycle.

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clk is the clock.
  - rst_n low clears div_cnt, pwm_cnt, duty and mode_q.
  - dir = up, led = 0, cycle_done = 0.
- Counter widths: pwm_cnt and duty are clog2(STEPS+1) bits; div_cnt is clog2(CLK_DIV) bits (minimum 1).
- Tick divider:
  - div_cnt counts 0..CLK_DIV-1, then wraps.
  - tick = (div_cnt == CLK_DIV-1), combinational and internal.
- PWM counter:
  - pwm_cnt advances on tick and wraps STEPS-1 -> 0.
  - period_end = tick && pwm_cnt == STEPS-1.
- Mode sampling: mode is sampled into mode_q only on period_end. Mode changes mid-period take effect at the next period start; there are no glitch pulses.
- Duty ramp: duty range 0..STEPS; it updates only on period_end and only while mode_q == breathe or blink.
  - dir up: duty+1; when the new value is STEPS, dir <= down.
  - dir down: duty-1; when the new value is 0, dir <= up and cycle_done pulses for exactly one clk, coincident with that duty update.
  - Full cycle: duty sequence 0,1..STEPS..1,0, which is 2*STEPS periods.
  - Default timing: 1 ms period, 2.0 s breath.
- Per-channel duty: duty_i = phase_inv[i] ? STEPS-duty : duty.
- LED output, registered with 1 clk latency from the counter state:
  - off: led[i] <= 0.
  - on: led[i] <= 1; phase_inv is ignored.
  - breathe: led[i] <= (pwm_cnt < duty_i).
    - duty_i = 0: constantly low.
    - duty_i = STEPS: constantly high.
  - blink: led[i] <= (dir == down) ^ phase_inv[i]. Each level is held for STEPS periods.
- Ramp hold outside breathe/blink: in off/on, duty and dir hold their values. Returning to breathe resumes the ramp from the held point.
- Enable:
  - en low, synchronous: next clk, all counters, duty and mode_q clear, dir = up, led = 0, cycle_done = 0.
  - en rising: counting restarts from div_cnt = 0.
  - mode_q stays off until the first period_end after en rises.
- Reset mid-operation: rst_n has the same effect as en low but is immediate (asynchronous).

Test Plan:
- Bench parameters: CLK_DIV=2, STEPS=4, CH=4. Period = 8 clks; full breathe cycle = 64 clks.
- Reset: assert rst_n=0 for 3 clks, en=1, mode=10 -> led=0000 and cycle_done=0 during reset. During the first period (mode_q still off), led stays 0000.
- Breathe ramp, phase_inv=0:
  - Per successive period, led high-clks out of 8 are 0,2,4,6,8,6,4,2.
  - cycle_done is a single-clk pulse on the period_end that returns duty to 0.
  - It repeats every 64 clks.
- Complementary channels, phase_inv=1010: channels 1 and 3 high-clks are 8,6,4,2,0,2,4,6 while channels 0 and 2 follow 0,2,4,6,8,...; at duty=2 all channels show 4/8.
- Mode switch mid-period: change 10 -> 01 at clk 3 of a period -> led unchanged until period_end, then 1111 one clk later. Switching back to 10 resumes the held duty.
- Blink, phase_inv=0001: led = 1110 for 4 periods (32 clks), then 0001 for 4 periods, alternating.
- en drop mid-ramp at duty=3: next clk led=0000 and counters are cleared. Re-assert en -> first breathe period after re-enable starts at duty 0 and shows 0/8 high.

Source files
------------

// File: rtl/led_breath_if.sv
// led_breath_if - control/status bundle for the LED dimming controller.
//
// Signals:
//   en          enable; low holds the controller idle
//   mode        00 off, 01 on, 10 breathe, 11 blink
//   phase_inv   per-channel inversion (complementary duty / inverted blink)
//   led         registered LED drive, active high
//   cycle_done  one-clk pulse at the end of each full breathe cycle
//
// master: the side that commands the controller (system logic or bench).
// slave : the controller itself.
interface led_breath_if #(
  parameter int CH = 4
);
  logic          en;
  logic [1:0]    mode;
  logic [CH-1:0] phase_inv;
  logic [CH-1:0] led;
  logic          cycle_done;

  modport master (
    output en,
    output mode,
    output phase_inv,
    input  led,
    input  cycle_done
  );

  modport slave (
    input  en,
    input  mode,
    input  phase_inv,
    output led,
    output cycle_done
  );
endinterface

// File: rtl/led_breath_ctrl.sv
// led_breath_ctrl - multi-channel LED dimming controller.
//
// A tick divider (CLK_DIV clks per tick) drives a PWM counter of STEPS ticks
// per period. Once per period a duty value ramps 0..STEPS..0, which gives a
// breathing effect; the same ramp direction also drives a slow blink.
// The mode input is only taken at period boundaries so a mode change never
// produces a partial PWM pulse.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    led_breath_if.slave: en, mode, phase_inv in; led, cycle_done out
module led_breath_ctrl #(
  parameter int CLK_DIV = 50,
  parameter int STEPS   = 1000,
  parameter int CH      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  led_breath_if.slave  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(STEPS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PWM_LAST = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] DUTY_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [CNT_W-1:0] pwm_cnt_reg, pwm_cnt_next;
  logic [CNT_W-1:0] duty_reg, duty_next;
  mode_t            mode_q_reg, mode_q_next;
  dir_t             dir_reg, dir_next;
  logic [CH-1:0]    led_reg, led_next;
  logic             cycle_done_reg, cycle_done_next;

  logic             tick;
  logic             period_end;
  logic             ramp_active;
  logic [CNT_W-1:0] duty_ch [CH];

  assign tick        = (div_cnt_reg == DIV_LAST);
  assign period_end  = tick && (pwm_cnt_reg == PWM_LAST);
  assign ramp_active = (mode_q_reg == MODE_BREATHE) || (mode_q_reg == MODE_BLINK);

  // Inverted channels run the complementary duty so that pairs cross-fade.
  for (genvar gi = 0; gi < CH; gi++) begin : g_duty
    assign duty_ch[gi] = bus.phase_inv[gi] ? (DUTY_MAX - duty_reg) : duty_reg;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg    <= '0;
      pwm_cnt_reg    <= '0;
      duty_reg       <= '0;
      mode_q_reg     <= MODE_OFF;
      dir_reg        <= DIR_UP;
      led_reg        <= '0;
      cycle_done_reg <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      pwm_cnt_reg    <= pwm_cnt_next;
      duty_reg       <= duty_next;
      mode_q_reg     <= mode_q_next;
      dir_reg        <= dir_next;
      led_reg        <= led_next;
      cycle_done_reg <= cycle_done_next;
    end
  end

  // Next-state logic: counters, mode sampling and duty ramp.
  always_comb begin
    div_cnt_next    = tick ? '0 : div_cnt_reg + 1'b1;
    pwm_cnt_next    = pwm_cnt_reg;
    mode_q_next     = mode_q_reg;
    duty_next       = duty_reg;
    dir_next        = dir_reg;
    cycle_done_next = 1'b0;

    if (tick) begin
      pwm_cnt_next = (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
    end

    if (period_end) begin
      mode_q_next = mode_t'(bus.mode);
      // The ramp decision uses the mode of the period just ending; in
      // off/on the ramp position is frozen so breathe resumes where it left.
      if (ramp_active) begin
        if (dir_reg == DIR_UP) begin
          duty_next = duty_reg + 1'b1;
          if (duty_reg == PWM_LAST) begin
            dir_next = DIR_DOWN;
          end
        end else begin
          duty_next = duty_reg - 1'b1;
          if (duty_reg == DUTY_ONE) begin
            dir_next        = DIR_UP;
            cycle_done_next = 1'b1;
          end
        end
      end
    end

    if (!bus.en) begin
      div_cnt_next    = '0;
      pwm_cnt_next    = '0;
      mode_q_next     = MODE_OFF;
      duty_next       = '0;
      dir_next        = DIR_UP;
      cycle_done_next = 1'b0;
    end
  end

  // LED drive, registered one clk after the counter state it reflects.
  always_comb begin
    led_next = '0;
    for (int i = 0; i < CH; i++) begin
      case (mode_q_reg)
        MODE_ON:      led_next[i] = 1'b1;
        MODE_BREATHE: led_next[i] = (pwm_cnt_reg < duty_ch[i]);
        MODE_BLINK:   led_next[i] = (dir_reg == DIR_DOWN) ^ bus.phase_inv[i];
        default:      led_next[i] = 1'b0;
      endcase
    end
    if (!bus.en) begin
      led_next = '0;
    end
  end

  assign bus.led        = led_reg;
  assign bus.cycle_done = cycle_done_reg;

endmodule

// File: tb/tb_led_breath_ctrl.sv
// tb_led_breath_ctrl - scoreboard bench for led_breath_ctrl
// (CLK_DIV=2, STEPS=4, CH=4: 8 clks per PWM period).
//
// The stimulus process walks period by period, pushing the hand-computed
// number of high clks per channel (and cycle_done clks) for each period.
// The monitor counts led samples over each 8-clk window and pops/compares.
module tb_led_breath_ctrl;

  localparam int CH  = 4;
  localparam int PER = 8;

  typedef struct {
    string name;
    int    h0;
    int    h1;
    int    h2;
    int    h3;
    int    cd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  led_breath_if #(.CH(CH)) bus ();

  led_breath_ctrl #(
    .CLK_DIV (2),
    .STEPS   (4),
    .CH      (CH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   mon_run = 1'b0;
  int   sync_id = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input string name, input int c0, input int c1,
                      input int c2, input int c3, input int cd);
    exp_t e;
    e.name = name; e.h0 = c0; e.h1 = c1; e.h2 = c2; e.h3 = c3; e.cd = cd;
    exp_q.push_back(e);
  endtask

  task automatic run_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic period(input string name, input int c0, input int c1,
                        input int c2, input int c3, input int cd);
    push(name, c0, c1, c2, c3, cd);
    run_clks(PER);
  endtask

  // Monitor: window p covers the led samples driven by period p's state.
  initial begin
    int   seen_sync = 0;
    int   ph = 0;
    int   acc[CH];
    int   cd_acc = 0;
    exp_t e;
    foreach (acc[i]) acc[i] = 0;
    forever begin
      @(negedge clk);
      if (mon_run) begin
        if (sync_id != seen_sync) begin
          // First sample after (re)start still reflects the cleared state.
          seen_sync = sync_id;
          ph = 0;
          cd_acc = 0;
          foreach (acc[i]) acc[i] = 0;
        end else begin
          for (int i = 0; i < CH; i++) acc[i] += int'(bus.led[i]);
          cd_acc += int'(bus.cycle_done);
          ph++;
          if (ph == PER) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_window: got led_hi=%0d/%0d/%0d/%0d, expected no window",
                       acc[0], acc[1], acc[2], acc[3]);
            end else begin
              e = exp_q.pop_front();
              chk({e.name, "_ch0"}, acc[0], e.h0);
              chk({e.name, "_ch1"}, acc[1], e.h1);
              chk({e.name, "_ch2"}, acc[2], e.h2);
              chk({e.name, "_ch3"}, acc[3], e.h3);
              chk({e.name, "_cycle_done"}, cd_acc, e.cd);
              $display("window %s: led_hi=%0d/%0d/%0d/%0d cycle_done=%0d",
                       e.name, acc[0], acc[1], acc[2], acc[3], cd_acc);
            end
            ph = 0;
            cd_acc = 0;
            foreach (acc[i]) acc[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ramp [8];
    int inv  [8];
    ramp = '{0, 2, 4, 6, 8, 6, 4, 2};
    inv  = '{8, 6, 4, 2, 0, 2, 4, 6};

    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.mode      = 2'b10;
    bus.phase_inv = 4'b0000;

    // Held in reset: outputs quiet.
    repeat (3) begin
      @(negedge clk);
      chk("reset_led", int'(bus.led), 0);
      chk("reset_cycle_done", int'(bus.cycle_done), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync_id++;
    mon_run = 1'b1;

    // p0: mode_q still off. Then two full breathe cycles.
    period("first_period", 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 8; k++) begin
        period($sformatf("breathe_c%0d_p%0d", c, k),
               ramp[k], ramp[k], ramp[k], ramp[k], (k == 7) ? 1 : 0);
      end
    end

    // Complementary channels 1 and 3.
    bus.phase_inv = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      period($sformatf("compl_p%0d", k),
             ramp[k], inv[k], ramp[k], inv[k], (k == 7) ? 1 : 0);
    end

    // Mode switch 10 -> 01 at clk 3 of the duty=2 period.
    bus.phase_inv = 4'b0000;
    period("pre_switch_d0", 0, 0, 0, 0, 0);
    period("pre_switch_d1", 2, 2, 2, 2, 0);
    push("switch_period", 4, 4, 4, 4, 0);
    run_clks(3);
    bus.mode = 2'b01;
    run_clks(PER - 3);
    period("on_1", 8, 8, 8, 8, 0);
    bus.mode = 2'b10;
    period("on_2", 8, 8, 8, 8, 0);
    period("resume_d3", 6, 6, 6, 6, 0);
    period("resume_d4", 8, 8, 8, 8, 0);

    // Blink with channel 0 inverted; last breathe period first.
    bus.mode = 2'b11;
    period("resume_d3_down", 6, 6, 6, 6, 0);
    bus.phase_inv = 4'b0001;
    period("blink_down_a", 0, 8, 8, 8, 0);
    period("blink_down_b", 0, 8, 8, 8, 1);
    for (int k = 0; k < 4; k++) period($sformatf("blink_up_%0d", k), 8, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) period($sformatf("blink_down_%0d", k), 0, 8, 8, 8, (k == 3) ? 1 : 0);
    for (int k = 0; k < 4; k++) period($sformatf("blink_up2_%0d", k), 8, 0, 0, 0, 0);

    // Back to breathe; blink (down) shows for one more period, then duty 3.
    bus.mode      = 2'b10;
    bus.phase_inv = 4'b0000;
    period("blink_to_breathe", 8, 8, 8, 8, 0);

    // en drop two clks into the duty=3 period.
    run_clks(2);
    mon_run = 1'b0;
    bus.en  = 1'b0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("en_low_led", int'(bus.led), 0);
      chk("en_low_cycle_done", int'(bus.cycle_done), 0);
    end
    @(posedge clk);
    #1;
    bus.en = 1'b1;
    sync_id++;
    mon_run = 1'b1;
    period("reen_mode_off", 0, 0, 0, 0, 0);
    period("reen_d0", 0, 0, 0, 0, 0);
    period("reen_d1", 2, 2, 2, 2, 0);
    period("reen_d2", 4, 4, 4, 4, 0);

    // Asynchronous reset while the LEDs are lit (duty=3, early in period).
    @(negedge clk);
    #1;
    mon_run = 1'b0;
    run_clks(3);
    chk("pre_async_led", int'(bus.led), 15);
    rst_n = 1'b0;
    #1;
    chk("async_reset_led", int'(bus.led), 0);
    chk("async_reset_cycle_done", int'(bus.cycle_done), 0);

    begin
      int waited = 0;
      while (exp_q.size() != 0 && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_windows: got %0d left, expected 0", exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
